// File: rtl/aclk_pkg.sv
// Shared types and BCD helpers for the multi-alarm clock.
// Limits are BCD-encoded so they compare directly against time fields.
package aclk_pkg;

  localparam logic [7:0] BCD_HH_MAX    = 8'h23;
  localparam logic [7:0] BCD_MM_MAX    = 8'h59;
  localparam logic [3:0] BCD_DIGIT_MAX = 4'h9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } state_t;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic bcd_valid(
    input logic [7:0] v,
    input logic [7:0] max
  );
    return (v[7:4] <= BCD_DIGIT_MAX) &&
           (v[3:0] <= BCD_DIGIT_MAX) &&
           (v <= max);
  endfunction

  // Returns {carry, next}; carry is set when v wraps from max to 00.
  function automatic logic [8:0] bcd_inc(
    input logic [7:0] v,
    input logic [7:0] max
  );
    logic [8:0] r;
    if (v >= max)
      r = {1'b1, 8'h00};
    else if (v[3:0] >= BCD_DIGIT_MAX)
      r = {1'b0, v[7:4] + 4'd1, 4'h0};
    else
      r = {1'b0, v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/alarm_slot_bank.sv
// Alarm slot registers with a validated write port and
// a lowest-index-wins match against the current time.
module alarm_slot_bank
  import aclk_pkg::*;
#(
  parameter int NUM_ALARMS = 4,
  parameter int SW         = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [SW-1:0] i_sel,
  input  logic [7:0]    i_hh,
  input  logic [7:0]    i_mm,
  input  logic          i_en,
  input  logic          i_chk,
  input  logic [7:0]    i_cur_hh,
  input  logic [7:0]    i_cur_mm,
  output logic          o_match,
  output logic [SW-1:0] o_match_id
);

  logic [7:0]            r_hh [NUM_ALARMS];
  logic [7:0]            r_mm [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] r_en;
  logic                  w_wr_ok;

  assign w_wr_ok = i_we &&
                   (32'(i_sel) < 32'(NUM_ALARMS)) &&
                   bcd_valid(i_hh, BCD_HH_MAX) &&
                   bcd_valid(i_mm, BCD_MM_MAX);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        r_hh[i] <= 8'h00;
        r_mm[i] <= 8'h00;
      end
      r_en <= '0;
    end else if (w_wr_ok) begin
      r_hh[i_sel] <= i_hh;
      r_mm[i_sel] <= i_mm;
      r_en[i_sel] <= i_en;
    end
  end

  // Scan high to low so the lowest matching index is written last.
  always_comb begin
    o_match    = 1'b0;
    o_match_id = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (i_chk && r_en[i] &&
          (r_hh[i] == i_cur_hh) &&
          (r_mm[i] == i_cur_mm)) begin
        o_match    = 1'b1;
        o_match_id = SW'(i);
      end
    end
  end

endmodule

// File: rtl/multi_alarm_clock.sv
// 24-hour BCD clock with a bank of alarm slots and a
// ring / snooze / auto-silence controller.
module multi_alarm_clock
  import aclk_pkg::*;
#(
  parameter int NUM_ALARMS       = 4,
  parameter int TICKS_PER_SEC    = 256,
  parameter int SNOOZE_MIN       = 5,
  parameter int RING_TIMEOUT_MIN = 10
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         fastwatch,
  input  logic                         load_time,
  input  logic                         load_alarm,
  input  logic [sel_w(NUM_ALARMS)-1:0] alarm_sel,
  input  logic [7:0]                   new_hh,
  input  logic [7:0]                   new_mm,
  input  logic                         alarm_en_wr,
  input  logic                         snooze,
  input  logic                         stop_alarm,
  output logic [7:0]                   cur_hh,
  output logic [7:0]                   cur_mm,
  output logic [7:0]                   cur_ss,
  output logic                         one_second,
  output logic                         alarm_sound,
  output logic [sel_w(NUM_ALARMS)-1:0] ringing_id,
  output logic                         snoozed
);

  localparam int SW = sel_w(NUM_ALARMS);
  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [3:0] SNZ_INIT = 4'(SNOOZE_MIN);
  localparam logic [3:0] RING_LIM = 4'(RING_TIMEOUT_MIN);

  logic [PW-1:0] r_pre;
  logic [7:0]    r_hh;
  logic [7:0]    r_mm;
  logic [7:0]    r_ss;
  logic          r_min_tick;
  logic          r_chk;
  state_t        r_state;
  logic [3:0]    r_ring_min;
  logic [3:0]    r_snz_cnt;
  logic [SW-1:0] r_id;

  logic          w_tick;
  logic          w_load_ok;
  logic [8:0]    w_hh_inc;
  logic [8:0]    w_mm_inc;
  logic [8:0]    w_ss_inc;
  logic          w_chk;
  logic          w_match;
  logic [SW-1:0] w_match_id;
  logic [3:0]    w_ring_inc;
  state_t        w_state_nxt;
  logic [3:0]    w_ring_nxt;
  logic [3:0]    w_snz_nxt;
  logic [SW-1:0] w_id_nxt;

  assign w_tick    = (r_pre == PRE_MAX);
  assign w_load_ok = load_time &&
                     bcd_valid(new_hh, BCD_HH_MAX) &&
                     bcd_valid(new_mm, BCD_MM_MAX);
  assign w_hh_inc  = bcd_inc(r_hh, BCD_HH_MAX);
  assign w_mm_inc  = bcd_inc(r_mm, BCD_MM_MAX);
  assign w_ss_inc  = bcd_inc(r_ss, BCD_MM_MAX);

  // A load always wins over a tick and never produces a minute event.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pre      <= '0;
      r_hh       <= 8'h00;
      r_mm       <= 8'h00;
      r_ss       <= 8'h00;
      r_min_tick <= 1'b0;
      r_chk      <= 1'b0;
    end else if (w_load_ok) begin
      r_pre      <= '0;
      r_hh       <= new_hh;
      r_mm       <= new_mm;
      r_ss       <= 8'h00;
      r_min_tick <= 1'b0;
      r_chk      <= 1'b0;
    end else begin
      r_pre      <= w_tick ? '0 : r_pre + PW'(1);
      r_min_tick <= 1'b0;
      r_chk      <= r_min_tick;
      if (w_tick) begin
        if (fastwatch || w_ss_inc[8]) begin
          r_ss       <= 8'h00;
          r_mm       <= w_mm_inc[7:0];
          r_min_tick <= 1'b1;
          if (w_mm_inc[8])
            r_hh <= w_hh_inc[7:0];
        end else begin
          r_ss <= w_ss_inc[7:0];
        end
      end
    end
  end

  assign w_chk = r_chk && ((r_ss == 8'h00) || fastwatch);

  alarm_slot_bank #(
    .NUM_ALARMS (NUM_ALARMS),
    .SW         (SW)
  ) u_bank (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_we       (load_alarm),
    .i_sel      (alarm_sel),
    .i_hh       (new_hh),
    .i_mm       (new_mm),
    .i_en       (alarm_en_wr),
    .i_chk      (w_chk),
    .i_cur_hh   (r_hh),
    .i_cur_mm   (r_mm),
    .o_match    (w_match),
    .o_match_id (w_match_id)
  );

  assign w_ring_inc = (r_ring_min == 4'hF) ? 4'hF
                                           : r_ring_min + 4'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ring_min <= 4'd0;
      r_snz_cnt  <= 4'd0;
      r_id       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ring_min <= w_ring_nxt;
      r_snz_cnt  <= w_snz_nxt;
      r_id       <= w_id_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ring_nxt  = r_ring_min;
    w_snz_nxt   = r_snz_cnt;
    w_id_nxt    = r_id;
    unique case (r_state)
      IDLE: begin
        if (w_match) begin
          w_state_nxt = RINGING;
          w_id_nxt    = w_match_id;
          w_ring_nxt  = 4'd0;
        end
      end
      RINGING: begin
        if (stop_alarm) begin
          w_state_nxt = IDLE;
        end else if (snooze) begin
          w_state_nxt = SNOOZED;
          w_snz_nxt   = SNZ_INIT;
        end else if (r_min_tick) begin
          w_ring_nxt = w_ring_inc;
          if (w_ring_inc >= RING_LIM)
            w_state_nxt = IDLE;
        end
      end
      SNOOZED: begin
        if (stop_alarm) begin
          w_state_nxt = IDLE;
        end else if (w_match) begin
          w_state_nxt = RINGING;
          w_id_nxt    = w_match_id;
          w_ring_nxt  = 4'd0;
        end else if (r_min_tick) begin
          if (r_snz_cnt <= 4'd1) begin
            w_snz_nxt   = 4'd0;
            w_state_nxt = RINGING;
            w_ring_nxt  = 4'd0;
          end else begin
            w_snz_nxt = r_snz_cnt - 4'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign cur_hh      = r_hh;
  assign cur_mm      = r_mm;
  assign cur_ss      = r_ss;
  assign one_second  = w_tick;
  assign alarm_sound = (r_state == RINGING);
  assign snoozed     = (r_state == SNOOZED);
  assign ringing_id  = r_id;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed bench for multi_alarm_clock with a 4-cycle second.
// Sampling happens 1 time unit after each rising edge.
module tb_multi_alarm_clock;

  logic       clock;
  logic       reset;
  logic       fastwatch;
  logic       load_time;
  logic       load_alarm;
  logic [1:0] alarm_sel;
  logic [7:0] new_hh;
  logic [7:0] new_mm;
  logic       alarm_en_wr;
  logic       snooze;
  logic       stop_alarm;
  logic [7:0] cur_hh;
  logic [7:0] cur_mm;
  logic [7:0] cur_ss;
  logic       one_second;
  logic       alarm_sound;
  logic [1:0] ringing_id;
  logic       snoozed;

  int n_vec = 0;
  int n_bad = 0;

  multi_alarm_clock #(
    .NUM_ALARMS       (4),
    .TICKS_PER_SEC    (4),
    .SNOOZE_MIN       (5),
    .RING_TIMEOUT_MIN (10)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .fastwatch   (fastwatch),
    .load_time   (load_time),
    .load_alarm  (load_alarm),
    .alarm_sel   (alarm_sel),
    .new_hh      (new_hh),
    .new_mm      (new_mm),
    .alarm_en_wr (alarm_en_wr),
    .snooze      (snooze),
    .stop_alarm  (stop_alarm),
    .cur_hh      (cur_hh),
    .cur_mm      (cur_mm),
    .cur_ss      (cur_ss),
    .one_second  (one_second),
    .alarm_sound (alarm_sound),
    .ringing_id  (ringing_id),
    .snoozed     (snoozed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_time(input logic [7:0] hh,
                          input logic [7:0] mm);
    load_time = 1'b1;
    new_hh    = hh;
    new_mm    = mm;
    cyc(1);
    load_time = 1'b0;
  endtask

  task automatic set_alarm(input logic [1:0] sel,
                           input logic [7:0] hh,
                           input logic [7:0] mm,
                           input logic en);
    load_alarm  = 1'b1;
    alarm_sel   = sel;
    new_hh      = hh;
    new_mm      = mm;
    alarm_en_wr = en;
    cyc(1);
    load_alarm  = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    fastwatch   = 1'b0;
    load_time   = 1'b0;
    load_alarm  = 1'b0;
    alarm_sel   = 2'd0;
    new_hh      = 8'h00;
    new_mm      = 8'h00;
    alarm_en_wr = 1'b0;
    snooze      = 1'b0;
    stop_alarm  = 1'b0;
    cyc(2);
    check("rst_time", {8'h0, cur_hh, cur_mm, cur_ss}, 32'h000000);
    check("rst_sound", alarm_sound, 0);
    check("rst_snoozed", snoozed, 0);
    check("rst_id", ringing_id, 0);
    check("rst_1s", one_second, 0);
    reset = 1'b0;

    // Rollover: 23:59:00 + 60 s at 4 cycles per second.
    set_time(8'h23, 8'h59);
    check("load_time", {8'h0, cur_hh, cur_mm, cur_ss}, 32'h235900);
    check("1s_pre0", one_second, 0);
    cyc(2);
    check("1s_pre2", one_second, 0);
    cyc(1);
    check("1s_pre3", one_second, 1);
    cyc(1);
    check("ss_01", cur_ss, 8'h01);
    cyc(235);
    check("pre_roll", {8'h0, cur_hh, cur_mm, cur_ss}, 32'h235959);
    cyc(1);
    check("roll", {8'h0, cur_hh, cur_mm, cur_ss}, 32'h000000);

    // Invalid time loads are ignored.
    set_time(8'h24, 8'h30);
    check("bad_hh", {cur_hh, cur_mm}, 16'h0000);
    set_time(8'h12, 8'h5A);
    check("bad_mm", {cur_hh, cur_mm}, 16'h0000);

    // Slot 1 rings at 06:59; its bad rewrite must not disable it.
    set_alarm(2'd0, 8'h07, 8'h00, 1'b0);
    set_alarm(2'd2, 8'h07, 8'h00, 1'b1);
    set_alarm(2'd3, 8'h07, 8'h00, 1'b1);
    set_alarm(2'd1, 8'h06, 8'h59, 1'b1);
    set_alarm(2'd1, 8'h1F, 8'h59, 1'b0);

    fastwatch = 1'b1;
    set_time(8'h06, 8'h58);
    cyc(4);
    check("fw_0659", {cur_hh, cur_mm, cur_ss}, 24'h065900);
    cyc(2);
    check("s1_sound", alarm_sound, 1);
    check("s1_id", ringing_id, 1);
    stop_alarm = 1'b1;
    cyc(1);
    stop_alarm = 1'b0;
    check("s1_stop", alarm_sound, 0);
    cyc(1);
    check("fw_0700", {cur_hh, cur_mm}, 16'h0700);
    check("edge0_sound", alarm_sound, 0);
    cyc(1);
    check("edge1_sound", alarm_sound, 0);
    cyc(1);
    check("edge2_sound", alarm_sound, 1);
    check("prio_id", ringing_id, 2);

    // Snooze for five minute ticks, then ring again.
    snooze = 1'b1;
    cyc(1);
    snooze = 1'b0;
    check("snz_flag", snoozed, 1);
    check("snz_sound", alarm_sound, 0);
    check("snz_id", ringing_id, 2);
    cyc(17);
    check("snz_hold", snoozed, 1);
    check("snz_mm", cur_mm, 8'h05);
    cyc(1);
    check("rering_sound", alarm_sound, 1);
    check("rering_snz", snoozed, 0);
    check("rering_id", ringing_id, 2);
    stop_alarm = 1'b1;
    snooze     = 1'b1;
    cyc(1);
    stop_alarm = 1'b0;
    snooze     = 1'b0;
    check("stop_prio_snd", alarm_sound, 0);
    check("stop_prio_snz", snoozed, 0);

    // Unattended ring ends on the tenth minute tick.
    set_time(8'h06, 8'h59);
    cyc(6);
    check("to_start", alarm_sound, 1);
    check("to_id", ringing_id, 2);
    cyc(38);
    check("to_9", alarm_sound, 1);
    cyc(1);
    check("to_10", alarm_sound, 0);

    // Slot 3 preempts a snooze, then reset clears everything.
    set_alarm(2'd3, 8'h07, 8'h02, 1'b1);
    set_time(8'h06, 8'h59);
    cyc(6);
    check("pre_ring", ringing_id, 2);
    snooze = 1'b1;
    cyc(1);
    snooze = 1'b0;
    check("pre_snz", snoozed, 1);
    cyc(6);
    check("pre_snz_hold", snoozed, 1);
    cyc(1);
    check("preempt_snd", alarm_sound, 1);
    check("preempt_id", ringing_id, 3);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("mid_rst_snd", alarm_sound, 0);
    check("mid_rst_id", ringing_id, 0);
    check("mid_rst_time", {8'h0, cur_hh, cur_mm, cur_ss}, 32'h000000);
    set_time(8'h06, 8'h59);
    cyc(6);
    check("en_clr_0700", alarm_sound, 0);
    cyc(8);
    check("en_clr_0702", alarm_sound, 0);
    check("en_clr_time", {cur_hh, cur_mm}, 16'h0702);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_alarm_clock.md
Name: multi_alarm_clock

Overview:
Self-contained 24-hour BCD clock with hours, minutes and seconds. It holds NUM_ALARMS independently enabled alarm slots and adds snooze and auto-silence. It is the next-generation timekeeping core: it replaces the single-alarm, minute-resolution path with a parametrised slot bank and a ring/snooze controller. Display encoding stays external; outputs are raw BCD.

Parameters:
NUM_ALARMS, 4, number of alarm slots (1..16)
TICKS_PER_SEC, 256, clock cycles per one_second pulse (>=2)
SNOOZE_MIN, 5, minutes between snooze and re-ring (1..15)
RING_TIMEOUT_MIN, 10, minutes of unattended ringing before auto-stop (1..15)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
fastwatch  in  1  1 = each second tick advances one minute
load_time  in  1  write new_hh/new_mm into current time
load_alarm  in  1  write new_hh/new_mm/alarm_en_wr into slot alarm_sel
alarm_sel  in  SW=max(1,$clog2(NUM_ALARMS))  slot index
new_hh  in  8  BCD hours, [7:4] tens, [3:0] units
new_mm  in  8  BCD minutes
alarm_en_wr  in  1  enable bit written with load_alarm
snooze  in  1  level, sampled each cycle
stop_alarm  in  1  level, sampled each cycle
cur_hh, cur_mm, cur_ss  out  8 each  current time, BCD
one_second  out  1  one-cycle pulse per second
alarm_sound  out  1  high while ringing
ringing_id  out  SW  slot that caused the current ring or snooze
snoozed  out  1  high in SNOOZED

Behaviour:
- Reset: time 00:00:00; all slots 00:00 with enable 0; prescaler 0; state IDLE; alarm_sound, snoozed, one_second 0; ringing_id 0.
- Prescaler counts 0..TICKS_PER_SEC-1. one_second is asserted in the cycle the count equals TICKS_PER_SEC-1, then the count wraps to 0.
- Normal mode: the seconds field increments on one_second. At 59 it wraps to 00 and raises minute_tick. Minutes wrap 59 to 00 and carry into hours; hours wrap 23 to 00.
- Fastwatch: each one_second increments minutes directly, cur_ss is held at 00, and minute_tick is raised.
- load_time: accepted only if the value is valid BCD, hh<=23 and mm<=59. On accept: time becomes hh:mm:00, prescaler is cleared, and there is no minute_tick that cycle. load_time beats a simultaneous tick. An invalid value is ignored entirely.
- load_alarm: same validity check; an invalid value leaves the slot unchanged. alarm_sel >= NUM_ALARMS is ignored. The write does not disturb the current state, even when it targets ringing_id.
- Match: evaluated on registered time in the cycle after minute_tick, with cur_ss==00 (or fastwatch). Lowest-index enabled slot whose hh:mm equals the current time wins. Load-induced time changes never match.
- FSM, states IDLE, RINGING, SNOOZED; transitions take effect at the next edge, so alarm_sound rises 2 cycles after the minute boundary edge.
  - IDLE -> RINGING on match; ringing_id <= winner; ring_min <= 0.
  - RINGING: stop_alarm -> IDLE. Otherwise snooze -> SNOOZED with snz_cnt <= SNOOZE_MIN. Otherwise each minute_tick increments ring_min; at RING_TIMEOUT_MIN -> IDLE. Stop has priority over snooze. A new match is ignored.
  - SNOOZED: stop_alarm -> IDLE. A new match preempts -> RINGING with the new id. Otherwise each minute_tick decrements snz_cnt; when it reaches 0 -> RINGING with the same id and ring_min <= 0.
- Disabling the ringing slot via load_alarm does not end ringing; only stop, timeout or reset do.
- Reset mid-ring or mid-snooze returns to IDLE immediately; alarm_sound is 0 on the next cycle.
- Counters: ring_min and snz_cnt are 4 bits, saturating, with no wrap.

Decomposition:
- Package aclk_pkg: BCD limit constants (23, 59, 9), state enum {IDLE, RINGING, SNOOZED}, a BCD validity function, and a BCD increment-with-wrap function.
- Sub-module alarm_slot_bank: slot register array, write port, and priority match outputting match and match_id.
- Timekeeping, prescaler and FSM stay in the top.

Test Plan:
- Count and rollover (TICKS_PER_SEC=4): load 23:59, then 60 seconds elapse -> after 240 cycles time reads 00:00:00; one_second pulses every 4 cycles.
- Invalid load: load_time with hh=8'h24, then mm=8'h5A -> time unchanged. load_alarm of 8'h1F into slot 1 -> slot 1 unchanged.
- Priority match: slots 0 (07:00, en=0), 2 (07:00, en=1) and 3 (07:00, en=1); fastwatch from 06:59 -> alarm_sound rises 2 cycles after cur_mm becomes 00; ringing_id=2.
- Snooze cycle: ring from slot 2, pulse snooze -> snoozed=1 and alarm_sound=0. After 5 minute_ticks -> RINGING again with ringing_id=2. Pulse stop_alarm together with snooze -> IDLE.
- Timeout: let the ring run unattended -> alarm_sound drops at the 10th minute_tick.
- Reset mid-ring and preempt: while SNOOZED, slot 3 matches -> RINGING with id 3. Assert reset -> next cycle alarm_sound=0, time 00:00:00, all enables 0.
